uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with runtime framing config and FWFT receive FIFO
module uart_rx_param #(
  parameter int FIFO_DEPTH = 16,
  parameter int OSR        = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Rx,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [1:0]                  cfg_len,
  input  logic [1:0]                  cfg_par,
  input  logic                        cfg_stop,
  input  logic                        read_enable,
  input  logic                        err_clr,
  output logic [7:0]                  rx_data,
  output logic                        valid,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun_err,
  output logic                        break_det
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(OSR);
  localparam logic [OW-1:0] S_LO = OW'(OSR/2-1);
  localparam logic [OW-1:0] S_MID = OW'(OSR/2);
  localparam logic [OW-1:0] S_HI = OW'(OSR/2+1);
  localparam logic [OW-1:0] S_LAST = OW'(OSR-1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic prev_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [OW-1:0] os_q, os_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [1:0] smp_q, smp_d;
  logic [1:0] len_q, len_d, par_q, par_d;
  logic stop2_q, stop2_d, sidx_q, sidx_d, pbit_q, pbit_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] level_q, level_d;
  logic fe_q, pe_q, ov_q, brk_q;
  logic rx_s, fall, tick, dec, b, push, set_fe, set_pe, set_brk, pop, full, wr, ovf;
  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;
  assign tick = div_q == cfg_div;
  assign dec = tick && os_q == S_HI;
  assign b = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign valid = level_q != '0;
  assign level = level_q;
  assign rx_data = valid ? mem_q[rptr_q] : 8'h00;
  assign pop = read_enable & valid;
  assign full = level_q == (AW+1)'(FIFO_DEPTH);
  assign wr = push & (~full | pop);
  assign ovf = push & full & ~pop;
  assign level_d = level_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
  assign frame_err = fe_q;
  assign parity_err = pe_q;
  assign overrun_err = ov_q;
  assign break_det = brk_q;
  // Frame FSM next state: sample collection, majority vote at the third mid-bit tick, framing checks
  always_comb begin
    state_d = state_q;
    div_d = tick ? '0 : div_q + DIV_W'(1);
    os_d = os_q;
    bit_d = bit_q;
    sh_d = sh_q;
    smp_d = smp_q;
    len_d = len_q;
    par_d = par_q;
    stop2_d = stop2_q;
    sidx_d = sidx_q;
    pbit_d = pbit_q;
    push = 1'b0;
    set_fe = 1'b0;
    set_pe = 1'b0;
    set_brk = 1'b0;
    if (tick) os_d = (os_q == S_LAST) ? '0 : os_q + OW'(1);
    if (tick && os_q == S_LO) smp_d[0] = rx_s;
    if (tick && os_q == S_MID) smp_d[1] = rx_s;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        div_d = '0;
        os_d = '0;
        bit_d = '0;
        sh_d = '0;
        sidx_d = 1'b0;
        pbit_d = 1'b0;
        len_d = cfg_len;
        par_d = cfg_par;
        stop2_d = cfg_stop;
      end
      START: if (dec) state_d = b ? IDLE : DATA;
      DATA: if (dec) begin
        sh_d[bit_q] = b;
        bit_d = bit_q + 3'd1;
        if (bit_q == {1'b1, len_q}) state_d = (par_q == 2'b01 || par_q == 2'b10) ? PARITY : STOP;
      end
      PARITY: if (dec) begin
        pbit_d = b;
        set_pe = (^sh_q ^ b) != par_q[1];
        state_d = STOP;
      end
      STOP: if (dec) begin
        if (!b) begin
          set_brk = !sidx_q && sh_q == 8'h00 && !pbit_q;
          set_fe = !set_brk;
          state_d = set_brk ? BRK_WAIT : IDLE;
        end else if (sidx_q == stop2_q) begin
          push = 1'b1;
          state_d = IDLE;
        end else sidx_d = 1'b1;
      end
      BRK_WAIT: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Synchroniser, receiver state, FIFO pointers and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      state_q <= IDLE;
      div_q <= '0;
      os_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      smp_q <= '0;
      len_q <= '0;
      par_q <= '0;
      stop2_q <= 1'b0;
      sidx_q <= 1'b0;
      pbit_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      fe_q <= 1'b0;
      pe_q <= 1'b0;
      ov_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], Rx};
      prev_q <= rx_s;
      state_q <= state_d;
      div_q <= div_d;
      os_q <= os_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      smp_q <= smp_d;
      len_q <= len_d;
      par_q <= par_d;
      stop2_q <= stop2_d;
      sidx_q <= sidx_d;
      pbit_q <= pbit_d;
      wptr_q <= wr ? wptr_q + AW'(1) : wptr_q;
      rptr_q <= pop ? rptr_q + AW'(1) : rptr_q;
      level_q <= level_d;
      fe_q <= set_fe | (fe_q & ~err_clr);
      pe_q <= set_pe | (pe_q & ~err_clr);
      ov_q <= ovf | (ov_q & ~err_clr);
      brk_q <= set_brk | (brk_q & ~err_clr);
    end
  end
  // FIFO storage, no reset needed since reads are masked by valid
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= sh_q;
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames with a queue scoreboard drained by a reading monitor
module tb_uart_rx_param;
  localparam int BIT = 64;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic Rx = 1'b1;
  logic [15:0] cfg_div;
  logic [1:0] cfg_len, cfg_par;
  logic cfg_stop, read_enable, err_clr;
  logic [7:0] rx_data;
  logic valid;
  logic [2:0] level;
  logic frame_err, parity_err, overrun_err, break_det;
  logic [7:0] exp_q[$];
  logic auto_rd = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int lat;

  uart_rx_param #(.FIFO_DEPTH(4), .OSR(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .Rx(Rx), .cfg_div(cfg_div), .cfg_len(cfg_len),
    .cfg_par(cfg_par), .cfg_stop(cfg_stop), .read_enable(read_enable),
    .err_clr(err_clr), .rx_data(rx_data), .valid(valid), .level(level),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err),
    .break_det(break_det)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    Rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int len, input logic has_par,
                      input logic pbit, input logic s1, input logic s2, input int nstop);
    bit_time(1'b0);
    for (int i = 0; i < len; i++) bit_time(d[i]);
    if (has_par) bit_time(pbit);
    bit_time(s1);
    if (nstop == 2) bit_time(s2);
    bit_time(1'b1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || valid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_done", k < 3000, 1);
  endtask

  task automatic clr_pulse();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  // Monitor: pops the scoreboard for every head presented while reading is enabled
  initial begin
    logic [7:0] e;
    read_enable = 1'b0;
    forever begin
      @(negedge clk);
      read_enable = 1'b0;
      if (auto_rd && rst && valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got %0h expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", rx_data, e);
        end
        read_enable = 1'b1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_div = 16'd3; cfg_len = 2'b11; cfg_par = 2'b00; cfg_stop = 1'b0; err_clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_level", level, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_flags", {frame_err, parity_err, overrun_err, break_det}, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    // 8N1 0xA5, head checked directly then drained
    lat = 0;
    fork
      send(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      while (!valid && lat < 800) begin @(negedge clk); lat++; end
    join
    chk("t1_latency_window", lat >= 600 && lat <= 640, 1);
    chk("t1_level", level, 1);
    chk("t1_valid", valid, 1);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_flags", {frame_err, parity_err, overrun_err, break_det}, 0);
    exp_q.push_back(8'hA5);
    auto_rd = 1'b1;
    drain();
    // 7E1 0x35 with wrong parity bit 1 (even parity would be 0)
    cfg_len = 2'b10; cfg_par = 2'b01;
    exp_q.push_back(8'h35);
    send(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    drain();
    chk("t2_parity_err", parity_err, 1);
    chk("t2_frame_err", frame_err, 0);
    clr_pulse();
    chk("t2_parity_clr", parity_err, 0);
    // false start: low for 2 ticks only
    cfg_len = 2'b11; cfg_par = 2'b00;
    Rx = 1'b0;
    repeat (8) @(negedge clk);
    Rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("t3_level", level, 0);
    chk("t3_flags", {frame_err, parity_err, overrun_err, break_det}, 0);
    // overrun with a 4-deep FIFO
    auto_rd = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    chk("t4_level", level, 4);
    chk("t4_overrun", overrun_err, 1);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    auto_rd = 1'b1;
    drain();
    chk("t4_level_empty", level, 0);
    clr_pulse();
    chk("t4_overrun_clr", overrun_err, 0);
    // break: 12 bit times low
    Rx = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    Rx = 1'b1;
    repeat (BIT) @(negedge clk);
    chk("t5_break", break_det, 1);
    chk("t5_frame_err", frame_err, 0);
    chk("t5_level", level, 0);
    exp_q.push_back(8'h5A);
    send(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    drain();
    clr_pulse();
    chk("t5_break_clr", break_det, 0);
    // 8O2 0x3C (odd parity bit 1) with second stop bit 0
    cfg_par = 2'b10; cfg_stop = 1'b1;
    send(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b0, 2);
    chk("t6_frame_err", frame_err, 1);
    chk("t6_parity_err", parity_err, 0);
    chk("t6_level", level, 0);
    // good 8O2 frame held in FIFO, then reset mid-frame
    auto_rd = 1'b0;
    send(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 2);
    chk("t7_level_pre", level, 1);
    Rx = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t7_rst_valid", valid, 0);
    chk("t7_rst_level", level, 0);
    chk("t7_rst_data", rx_data, 0);
    chk("t7_rst_flags", {frame_err, parity_err, overrun_err, break_det}, 0);
    Rx = 1'b1;
    @(negedge clk) rst = 1'b1;
    repeat (BIT) @(negedge clk);
    auto_rd = 1'b1;
    exp_q.push_back(8'hC3);
    send(8'hC3, 8, 1'b1, 1'b1, 1'b1, 1'b1, 2);
    drain();
    chk("t7_flags_after", {frame_err, parity_err, overrun_err, break_det}, 0);
    chk("sb_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
